us_lite_acq_regs: RTL and testbench

- Acquisition-control slave on the Xillybus Lite user port of the Zynq system wrapper.
- Decodes host register reads and writes, and drives one acquisition run at a time.
- Buffers ultrasound ADC samples in a synchronous FIFO that the host drains by reading a data register.
- Raises the user IRQ on FIFO threshold, run completion or overflow.

---
 rtl/us_lite_pkg.sv | 52 +++++
 rtl/us_lite_acq_regs_if.sv | 21 ++
 rtl/us_sync_fifo.sv | 67 ++++++
 rtl/us_lite_acq_regs.sv | 221 ++++++++++++++++++++++
 tb/tb_us_lite_acq_regs.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/us_lite_pkg.sv
// Shared definitions for the Xillybus Lite acquisition-control slave:
// register word indices, bit positions, FSM states and the FIFO entry layout.
package us_lite_pkg;

  localparam int unsigned ENTRY_W = 32;
  localparam int unsigned IRQ_W   = 3;

  // Word indices, i.e. byte offset >> 2
  localparam logic [4:0] ADDR_CTRL      = 5'h00;
  localparam logic [4:0] ADDR_STATUS    = 5'h01;
  localparam logic [4:0] ADDR_IRQ_STAT  = 5'h02;
  localparam logic [4:0] ADDR_THRESH    = 5'h03;
  localparam logic [4:0] ADDR_SCOUNT    = 5'h04;
  localparam logic [4:0] ADDR_FIFO_DATA = 5'h05;
  localparam logic [4:0] ADDR_ID        = 5'h06;
  localparam logic [4:0] ADDR_TSTAMP    = 5'h07;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_START  = 1;
  localparam int unsigned CTRL_CLR    = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;

  localparam int unsigned STAT_EMPTY = 0;
  localparam int unsigned STAT_FULL  = 1;
  localparam int unsigned STAT_BUSY  = 2;

  localparam int unsigned IRQ_THR  = 0;
  localparam int unsigned IRQ_DONE = 1;
  localparam int unsigned IRQ_OVF  = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CAPTURE = 1'b1
  } acq_state_e;

  typedef struct packed {
    logic [15:0] tstamp;
    logic [15:0] sample;
  } fifo_entry_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/us_lite_acq_regs_if.sv
// Xillybus Lite user-port bundle: host-driven strobes/address/data and the
// slave-driven read data and interrupt.
interface us_lite_acq_regs_if;
  logic        user_wren;
  logic [3:0]  user_wstrb;
  logic        user_rden;
  logic [31:0] user_addr;
  logic [31:0] user_wr_data;
  logic [31:0] user_rd_data;
  logic        user_irq;

  modport master (
    output user_wren, user_wstrb, user_rden, user_addr, user_wr_data,
    input  user_rd_data, user_irq
  );

  modport slave (
    input  user_wren, user_wstrb, user_rden, user_addr, user_wr_data,
    output user_rd_data, user_irq
  );
endinterface

// File: rtl/us_sync_fifo.sv
// Single-clock show-ahead FIFO with level/full/empty and synchronous clear.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module us_sync_fifo #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // Clear overrides any push or pop presented in the same cycle
  always_comb begin
    do_push  = push & ~clr & (~full | pop);
    do_pop   = pop & ~clr & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; contents are only observed while non-empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/us_lite_acq_regs.sv
// Acquisition-control slave on the Xillybus Lite user port: register file,
// single-run capture FSM, sample FIFO and interrupt generation.
// Optional US_LITE_TIMESTAMP_EN tags each FIFO entry with a free-running counter.
module us_lite_acq_regs
  import us_lite_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned SAMPLE_W   = 16,
  parameter logic [31:0] ID_VALUE   = 32'h5553_0001
) (
  input  logic                bus_clk,
  input  logic                bus_rst_n,
  us_lite_acq_regs_if.slave   bus,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic                acq_trigger,
  output logic                acq_busy
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  acq_state_e       state_q, state_d;
  logic             enable_q, enable_d;
  logic             irq_en_q, irq_en_d;
  logic [15:0]      thresh_q, thresh_d;
  logic [31:0]      scount_q, scount_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [IRQ_W-1:0] irq_stat_q, irq_stat_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             irq_q, irq_d;
  logic             trig_q, trig_d;

  logic [4:0]         idx_c;
  logic               ctrl_wr_c, start_ok_c, abort_c, clr_c, pop_c, push_c;
  logic               last_c, done_set_c, ovf_set_c, thr_hit_c;
  logic [IRQ_W-1:0]   w1c_c;
  fifo_entry_t        entry_c;
  logic [ENTRY_W-1:0] fifo_head;
  logic [LVL_W-1:0]   fifo_level;
  logic               fifo_full, fifo_empty;
  logic [31:0]        tstamp_rd_c;
  logic               unused_ok;

  assign unused_ok = ^{bus.user_addr[31:7], bus.user_addr[1:0]};

  // Address decode; start/abort use the enable value being written
  always_comb begin
    idx_c      = bus.user_addr[6:2];
    ctrl_wr_c  = bus.user_wren & (idx_c == ADDR_CTRL) & bus.user_wstrb[0];
    start_ok_c = ctrl_wr_c & bus.user_wr_data[CTRL_START] & bus.user_wr_data[CTRL_EN];
    abort_c    = ctrl_wr_c & ~bus.user_wr_data[CTRL_EN];
    clr_c      = ctrl_wr_c & bus.user_wr_data[CTRL_CLR];
    pop_c      = bus.user_rden & (idx_c == ADDR_FIFO_DATA);
    w1c_c      = '0;
    if (bus.user_wren && (idx_c == ADDR_IRQ_STAT) && bus.user_wstrb[0]) begin
      w1c_c = bus.user_wr_data[IRQ_W-1:0];
    end
    last_c = (cnt_q == scount_q - 32'd1);
  end

  // FSM state register
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_ok_c && (scount_q != 32'd0)) state_d = ST_CAPTURE;
      ST_CAPTURE: if (abort_c || (sample_valid && last_c)) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: trigger, sample push, run counter, done event
  always_comb begin
    trig_d     = 1'b0;
    done_set_c = 1'b0;
    push_c     = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_c) begin
          if (scount_q == 32'd0) begin
            done_set_c = 1'b1;
          end else begin
            trig_d = 1'b1;
            cnt_d  = '0;
          end
        end
      end
      ST_CAPTURE: begin
        if (sample_valid) begin
          push_c     = 1'b1;
          cnt_d      = cnt_q + 32'd1;
          done_set_c = last_c & ~abort_c;
        end
      end
      default: ;
    endcase
  end

  // RW register updates with byte enables
  always_comb begin
    enable_d = enable_q;
    irq_en_d = irq_en_q;
    thresh_d = thresh_q;
    scount_d = scount_q;
    if (ctrl_wr_c) begin
      enable_d = bus.user_wr_data[CTRL_EN];
      irq_en_d = bus.user_wr_data[CTRL_IRQ_EN];
    end
    if (bus.user_wren && (idx_c == ADDR_THRESH)) begin
      thresh_d = 16'(apply_wstrb({16'd0, thresh_q}, bus.user_wr_data, bus.user_wstrb));
    end
    if (bus.user_wren && (idx_c == ADDR_SCOUNT)) begin
      scount_d = apply_wstrb(scount_q, bus.user_wr_data, bus.user_wstrb);
    end
  end

  // Threshold is level-driven, so a W1C clears it for one cycle before it can
  // re-assert; done/overflow events win over a coincident W1C
  always_comb begin
    thr_hit_c  = (thresh_q != 16'd0) && (16'(fifo_level) >= thresh_q);
    ovf_set_c  = push_c & fifo_full & ~pop_c & ~clr_c;
    irq_stat_d = irq_stat_q;
    irq_stat_d[IRQ_THR]  = w1c_c[IRQ_THR] ? 1'b0 : (irq_stat_q[IRQ_THR] | thr_hit_c);
    irq_stat_d[IRQ_DONE] = (irq_stat_q[IRQ_DONE] & ~w1c_c[IRQ_DONE]) | done_set_c;
    irq_stat_d[IRQ_OVF]  = (irq_stat_q[IRQ_OVF] & ~w1c_c[IRQ_OVF]) | ovf_set_c;
    irq_d = irq_en_q & (|irq_stat_q);
  end

`ifdef US_LITE_TIMESTAMP_EN
  logic [15:0] tstamp_q, tstamp_d;

  always_comb tstamp_d = tstamp_q + 16'd1;

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) tstamp_q <= '0;
    else            tstamp_q <= tstamp_d;
  end

  always_comb begin
    entry_c.tstamp = tstamp_q;
    entry_c.sample = 16'(sample_data);
    tstamp_rd_c    = {16'd0, tstamp_q};
  end
`else
  always_comb begin
    entry_c.tstamp = '0;
    entry_c.sample = 16'(sample_data);
    tstamp_rd_c    = '0;
  end
`endif

  us_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (bus_clk),
    .rst_n (bus_rst_n),
    .clr   (clr_c),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (entry_c),
    .rdata (fifo_head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Read mux; data is held until the next read strobe
  always_comb begin
    rd_data_d = rd_data_q;
    if (bus.user_rden) begin
      case (idx_c)
        ADDR_CTRL:      rd_data_d = {28'd0, irq_en_q, 2'b00, enable_q};
        ADDR_STATUS:    rd_data_d = {16'(fifo_level), 13'd0, (state_q == ST_CAPTURE),
                                     fifo_full, fifo_empty};
        ADDR_IRQ_STAT:  rd_data_d = {29'd0, irq_stat_q};
        ADDR_THRESH:    rd_data_d = {16'd0, thresh_q};
        ADDR_SCOUNT:    rd_data_d = scount_q;
        ADDR_FIFO_DATA: rd_data_d = fifo_empty ? 32'd0 : fifo_head;
        ADDR_ID:        rd_data_d = ID_VALUE;
        ADDR_TSTAMP:    rd_data_d = tstamp_rd_c;
        default:        rd_data_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      thresh_q   <= '0;
      scount_q   <= '0;
      cnt_q      <= '0;
      irq_stat_q <= '0;
      rd_data_q  <= '0;
      irq_q      <= 1'b0;
      trig_q     <= 1'b0;
    end else begin
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      thresh_q   <= thresh_d;
      scount_q   <= scount_d;
      cnt_q      <= cnt_d;
      irq_stat_q <= irq_stat_d;
      rd_data_q  <= rd_data_d;
      irq_q      <= irq_d;
      trig_q     <= trig_d;
    end
  end

  assign bus.user_rd_data = rd_data_q;
  assign bus.user_irq     = irq_q;
  assign acq_trigger      = trig_q;
  assign acq_busy         = (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_us_lite_acq_regs.sv
// Directed-sequence bench with random sample data and addresses, checked
// against a transaction-level model (queue + status flags) of the slave.
module tb_us_lite_acq_regs;
  import us_lite_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] ID    = 32'h5553_0001;

  logic        bus_clk = 1'b0;
  logic        bus_rst_n;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        acq_trigger;
  logic        acq_busy;

  us_lite_acq_regs_if bus_if();

  us_lite_acq_regs #(
    .FIFO_DEPTH (DEPTH),
    .SAMPLE_W   (16),
    .ID_VALUE   (ID)
  ) dut (
    .bus_clk      (bus_clk),
    .bus_rst_n    (bus_rst_n),
    .bus          (bus_if),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .acq_trigger  (acq_trigger),
    .acq_busy     (acq_busy)
  );

  always #5 bus_clk = ~bus_clk;

  int trig_cnt = 0;
  always @(posedge bus_clk) if (acq_trigger === 1'b1) trig_cnt++;

  // Reference model state
  logic [31:0] mq[$];
  bit          m_cap, m_thr, m_done, m_ovf, m_irq_en;
  int unsigned m_scount, m_cnt, m_thresh;
  int          exp_trig;
  int          checks = 0;
  int          errors = 0;

  task automatic model_reset();
    mq.delete();
    m_cap = 0; m_thr = 0; m_done = 0; m_ovf = 0; m_irq_en = 0;
    m_scount = 0; m_cnt = 0; m_thresh = 0;
  endtask

  task automatic model_thr();
    if (m_thresh != 0 && mq.size() >= m_thresh) m_thr = 1;
  endtask

  function automatic logic [31:0] exp_status();
    return {16'(mq.size()), 13'd0, m_cap, (mq.size() == DEPTH), (mq.size() == 0)};
  endfunction

  function automatic logic [31:0] exp_irq_stat();
    return {29'd0, m_ovf, m_done, m_thr};
  endfunction

  function automatic logic exp_user_irq();
    return m_irq_en & (m_thr | m_done | m_ovf);
  endfunction

  function automatic logic [31:0] exp_fifo();
    return (mq.size() != 0) ? mq[0] : 32'd0;
  endfunction

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Only addr[6:2] is decoded, so the other bits are randomised
  function automatic logic [31:0] mk_addr(input logic [4:0] idx);
    logic [24:0] hi;
    logic [1:0]  lo;
    hi = 25'($urandom());
    lo = 2'($urandom());
    return {hi, idx, lo};
  endfunction

  task automatic wr(input logic [4:0] idx, input logic [31:0] d);
    bus_if.user_wren    = 1'b1;
    bus_if.user_wstrb   = 4'hF;
    bus_if.user_addr    = mk_addr(idx);
    bus_if.user_wr_data = d;
    tick();
    bus_if.user_wren = 1'b0;
    case (idx)
      ADDR_CTRL: begin
        if (d[2]) mq.delete();
        if (m_cap && !d[0]) m_cap = 0;
        else if (!m_cap && d[1] && d[0]) begin
          if (m_scount == 0) m_done = 1;
          else begin
            m_cap = 1; m_cnt = 0; exp_trig++;
          end
        end
        m_irq_en = d[3];
      end
      ADDR_IRQ_STAT: begin
        if (d[0]) m_thr = 0;
        if (d[1]) m_done = 0;
        if (d[2]) m_ovf = 0;
      end
      ADDR_THRESH: m_thresh = d[15:0];
      ADDR_SCOUNT: m_scount = d;
      default: ;
    endcase
    tick();
    model_thr();
  endtask

  task automatic rd(input logic [4:0] idx, output logic [31:0] d);
    bus_if.user_rden = 1'b1;
    bus_if.user_addr = mk_addr(idx);
    tick();
    bus_if.user_rden = 1'b0;
    d = bus_if.user_rd_data;
    if (idx == ADDR_FIFO_DATA && mq.size() != 0) void'(mq.pop_front());
    model_thr();
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    logic [31:0] d;
    rd(idx, d);
    check(tag, d, exp);
  endtask

  task automatic smp(input logic [15:0] v);
    sample_valid = 1'b1;
    sample_data  = v;
    tick();
    sample_valid = 1'b0;
    if (m_cap) begin
      if (mq.size() < DEPTH) mq.push_back({16'd0, v});
      else m_ovf = 1;
      m_cnt++;
      if (m_cnt == m_scount) begin
        m_done = 1; m_cap = 0;
      end
    end
    model_thr();
  endtask

  task automatic smp_burst(input int n);
    for (int i = 0; i < n; i++) smp(16'($urandom()));
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) rd_chk(tag, ADDR_FIFO_DATA, exp_fifo());
  endtask

  initial begin
    int n;
    bus_rst_n           = 1'b0;
    bus_if.user_wren    = 1'b0;
    bus_if.user_wstrb   = 4'h0;
    bus_if.user_rden    = 1'b0;
    bus_if.user_addr    = '0;
    bus_if.user_wr_data = '0;
    sample_valid        = 1'b0;
    sample_data         = '0;
    exp_trig            = 0;
    model_reset();

    // Reset state
    repeat (3) tick();
    check("rst_rd_data", bus_if.user_rd_data, 32'd0);
    check("rst_irq", 32'(bus_if.user_irq), 32'd0);
    check("rst_trig", 32'(acq_trigger), 32'd0);
    check("rst_busy", 32'(acq_busy), 32'd0);
    bus_rst_n = 1'b1;
    tick();
    rd_chk("id", ADDR_ID, ID);
    rd_chk("status_reset", ADDR_STATUS, 32'h0000_0001);
    rd_chk("unmapped", 5'h1F, 32'd0);

    // Basic 4-sample run
    wr(ADDR_SCOUNT, 32'd4);
    wr(ADDR_CTRL, 32'h0B);
    check("busy_run", 32'(acq_busy), 32'd1);
    rd_chk("ctrl_rb", ADDR_CTRL, 32'h09);
    for (int v = 16'h11; v <= 16'h14; v++) smp(16'(v));
    tick();
    check("trig_once", 32'(trig_cnt), 32'(exp_trig));
    check("busy_done", 32'(acq_busy), 32'd0);
    rd_chk("irq_done", ADDR_IRQ_STAT, exp_irq_stat());
    check("user_irq_done", 32'(bus_if.user_irq), 32'(exp_user_irq()));
    rd_chk("status_lvl4", ADDR_STATUS, exp_status());
    drain("fifo_run1", 5);
    rd_chk("status_drained", ADDR_STATUS, exp_status());
    wr(ADDR_IRQ_STAT, 32'h2);
    check("user_irq_clr", 32'(bus_if.user_irq), 32'(exp_user_irq()));

    // Start ignored while disabled; SCOUNT=0 gives done without a trigger
    wr(ADDR_CTRL, 32'h02);
    check("start_dis_trig", 32'(trig_cnt), 32'(exp_trig));
    check("start_dis_busy", 32'(acq_busy), 32'd0);
    wr(ADDR_SCOUNT, 32'd0);
    wr(ADDR_CTRL, 32'h0B);
    check("scount0_trig", 32'(trig_cnt), 32'(exp_trig));
    check("scount0_busy", 32'(acq_busy), 32'd0);
    rd_chk("scount0_done", ADDR_IRQ_STAT, exp_irq_stat());
    wr(ADDR_IRQ_STAT, 32'h2);

    // Overflow run with random length and data
    n = 17 + int'($urandom_range(0, 10));
    wr(ADDR_SCOUNT, 32'(n));
    wr(ADDR_CTRL, 32'h0B);
    smp_burst(n);
    tick();
    rd_chk("ovf_irq", ADDR_IRQ_STAT, exp_irq_stat());
    rd_chk("ovf_status", ADDR_STATUS, exp_status());
    wr(ADDR_IRQ_STAT, 32'h2);
    check("ovf_irq_held", 32'(bus_if.user_irq), 32'(exp_user_irq()));
    wr(ADDR_IRQ_STAT, 32'h4);
    check("ovf_irq_drop", 32'(bus_if.user_irq), 32'(exp_user_irq()));
    rd_chk("ovf_w1c", ADDR_IRQ_STAT, exp_irq_stat());
    drain("fifo_ovf", DEPTH);
    rd_chk("ovf_empty", ADDR_STATUS, exp_status());

    // Threshold set, re-assert after W1C, stays clear below threshold
    wr(ADDR_THRESH, 32'd3);
    wr(ADDR_SCOUNT, 32'd5);
    wr(ADDR_CTRL, 32'h0B);
    smp_burst(3);
    tick();
    rd_chk("thr_set", ADDR_IRQ_STAT, exp_irq_stat());
    rd_chk("thr_status", ADDR_STATUS, exp_status());
    wr(ADDR_IRQ_STAT, 32'h1);
    rd_chk("thr_reassert", ADDR_IRQ_STAT, exp_irq_stat());
    drain("fifo_thr", 1);
    wr(ADDR_IRQ_STAT, 32'h1);
    rd_chk("thr_clear", ADDR_IRQ_STAT, exp_irq_stat());
    smp_burst(2);
    tick();
    rd_chk("thr_done", ADDR_IRQ_STAT, exp_irq_stat());
    wr(ADDR_THRESH, 32'd0);
    wr(ADDR_IRQ_STAT, 32'h7);
    drain("fifo_thr2", 4);
    rd_chk("thr_final", ADDR_IRQ_STAT, exp_irq_stat());

    // Abort keeps FIFO and does not flag done; clear empties FIFO
    wr(ADDR_SCOUNT, 32'd10);
    wr(ADDR_CTRL, 32'h0B);
    smp_burst(2);
    wr(ADDR_CTRL, 32'h00);
    check("abort_busy", 32'(acq_busy), 32'd0);
    smp_burst(1);
    rd_chk("abort_status", ADDR_STATUS, exp_status());
    rd_chk("abort_irq", ADDR_IRQ_STAT, exp_irq_stat());
    wr(ADDR_CTRL, 32'h04);
    rd_chk("clear_status", ADDR_STATUS, exp_status());

    // Asynchronous reset in the middle of a run
    wr(ADDR_SCOUNT, 32'd10);
    wr(ADDR_CTRL, 32'h0B);
    smp_burst(3);
    rd_chk("pre_rst_id", ADDR_ID, ID);
    #2;
    bus_rst_n = 1'b0;
    #1;
    check("arst_rd_data", bus_if.user_rd_data, 32'd0);
    check("arst_irq", 32'(bus_if.user_irq), 32'd0);
    check("arst_trig", 32'(acq_trigger), 32'd0);
    check("arst_busy", 32'(acq_busy), 32'd0);
    model_reset();
    tick();
    bus_rst_n = 1'b1;
    tick();
    rd_chk("arst_status", ADDR_STATUS, exp_status());
    rd_chk("arst_scount", ADDR_SCOUNT, 32'd0);
    rd_chk("arst_ctrl", ADDR_CTRL, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
